// File: rtl/lut_sigmoid.sv
// ---------------------------------------------------------------------------
// lut_sigmoid
//
// Sigmoid activation by constant lookup. The signed Q4.4 pre-activation
// selects one of 256 precomputed entries, round_half_up(256/(1+e^-v)) with
// v = x/16. The result is registered and presented as unsigned Q8.8.
// Nothing is computed at run time.
//
// Ports
//   clk  : in  1  - sole clock, rising-edge
//   rst  : in  1  - synchronous active-high reset, clears sig to 0x0000
//   en   : in  1  - lookup enable; when low sig holds its value
//   x    : in  8  - pre-activation, two's-complement Q4.4
//   sig  : out 16 - sigmoid(x), unsigned Q8.8, range 0x0000..0x0100
//
// Latency is one cycle. Throughput is one lookup per cycle. sig is driven
// directly by a flop.
// ---------------------------------------------------------------------------
module lut_sigmoid (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  x,
    output logic [15:0] sig
);

    logic [15:0] w_entry;
    logic [15:0] r_sig;

    // Table contents, listed by raw code. Codes 0x00..0x7F are v = 0..7.9375.
    // Codes 0x80..0xFF are v = -8.0..-0.0625. Each negative entry is
    // 256 minus its positive mirror. 1.0 is kept as 0x0100 rather than
    // saturated, so the table stays exactly symmetric about 0x0080.
    always_comb begin
        w_entry = 16'd0;
        case (x)
            8'h00: w_entry = 16'd128;
            8'h01: w_entry = 16'd132;
            8'h02: w_entry = 16'd136;
            8'h03: w_entry = 16'd140;
            8'h04: w_entry = 16'd144;
            8'h05: w_entry = 16'd148;
            8'h06: w_entry = 16'd152;
            8'h07: w_entry = 16'd156;
            8'h08: w_entry = 16'd159;
            8'h09: w_entry = 16'd163;
            8'h0A: w_entry = 16'd167;
            8'h0B: w_entry = 16'd170;
            8'h0C: w_entry = 16'd174;
            8'h0D: w_entry = 16'd177;
            8'h0E: w_entry = 16'd181;
            8'h0F: w_entry = 16'd184;
            8'h10: w_entry = 16'd187;
            8'h11: w_entry = 16'd190;
            8'h12: w_entry = 16'd193;
            8'h13: w_entry = 16'd196;
            8'h14: w_entry = 16'd199;
            8'h15: w_entry = 16'd202;
            8'h16: w_entry = 16'd204;
            8'h17: w_entry = 16'd207;
            8'h18: w_entry = 16'd209;
            8'h19: w_entry = 16'd212;
            8'h1A: w_entry = 16'd214;
            8'h1B: w_entry = 16'd216;
            8'h1C: w_entry = 16'd218;
            8'h1D: w_entry = 16'd220;
            8'h1E: w_entry = 16'd222;
            8'h1F: w_entry = 16'd224;
            8'h20: w_entry = 16'd225;
            8'h21: w_entry = 16'd227;
            8'h22: w_entry = 16'd229;
            8'h23: w_entry = 16'd230;
            8'h24: w_entry = 16'd232;
            8'h25: w_entry = 16'd233;
            8'h26: w_entry = 16'd234;
            8'h27: w_entry = 16'd235;
            8'h28: w_entry = 16'd237;
            8'h29: w_entry = 16'd238;
            8'h2A: w_entry = 16'd239;
            8'h2B: w_entry = 16'd240;
            8'h2C: w_entry = 16'd241;
            8'h2D: w_entry = 16'd241;
            8'h2E: w_entry = 16'd242;
            8'h2F: w_entry = 16'd243;
            8'h30: w_entry = 16'd244;
            8'h31: w_entry = 16'd245;
            8'h32: w_entry = 16'd245;
            8'h33: w_entry = 16'd246;
            8'h34: w_entry = 16'd246;
            8'h35: w_entry = 16'd247;
            8'h36: w_entry = 16'd248;
            8'h37: w_entry = 16'd248;
            8'h38: w_entry = 16'd248;
            8'h39: w_entry = 16'd249;
            8'h3A: w_entry = 16'd249;
            8'h3B: w_entry = 16'd250;
            8'h3C: w_entry = 16'd250;
            8'h3D: w_entry = 16'd250;
            8'h3E: w_entry = 16'd251;
            8'h3F: w_entry = 16'd251;
            8'h40: w_entry = 16'd251;
            8'h41: w_entry = 16'd252;
            8'h42: w_entry = 16'd252;
            8'h43: w_entry = 16'd252;
            8'h44: w_entry = 16'd252;
            8'h45: w_entry = 16'd253;
            8'h46: w_entry = 16'd253;
            8'h47: w_entry = 16'd253;
            8'h48: w_entry = 16'd253;
            8'h49: w_entry = 16'd253;
            8'h4A: w_entry = 16'd254;
            8'h4B: w_entry = 16'd254;
            8'h4C: w_entry = 16'd254;
            8'h4D: w_entry = 16'd254;
            8'h4E: w_entry = 16'd254;
            8'h4F: w_entry = 16'd254;
            8'h50: w_entry = 16'd254;
            8'h51: w_entry = 16'd254;
            8'h52: w_entry = 16'd254;
            8'h53: w_entry = 16'd255;
            8'h54: w_entry = 16'd255;
            8'h55: w_entry = 16'd255;
            8'h56: w_entry = 16'd255;
            8'h57: w_entry = 16'd255;
            8'h58: w_entry = 16'd255;
            8'h59: w_entry = 16'd255;
            8'h5A: w_entry = 16'd255;
            8'h5B: w_entry = 16'd255;
            8'h5C: w_entry = 16'd255;
            8'h5D: w_entry = 16'd255;
            8'h5E: w_entry = 16'd255;
            8'h5F: w_entry = 16'd255;
            8'h60: w_entry = 16'd255;
            8'h61: w_entry = 16'd255;
            8'h62: w_entry = 16'd255;
            8'h63: w_entry = 16'd255;
            8'h64: w_entry = 16'd256;
            8'h65: w_entry = 16'd256;
            8'h66: w_entry = 16'd256;
            8'h67: w_entry = 16'd256;
            8'h68: w_entry = 16'd256;
            8'h69: w_entry = 16'd256;
            8'h6A: w_entry = 16'd256;
            8'h6B: w_entry = 16'd256;
            8'h6C: w_entry = 16'd256;
            8'h6D: w_entry = 16'd256;
            8'h6E: w_entry = 16'd256;
            8'h6F: w_entry = 16'd256;
            8'h70: w_entry = 16'd256;
            8'h71: w_entry = 16'd256;
            8'h72: w_entry = 16'd256;
            8'h73: w_entry = 16'd256;
            8'h74: w_entry = 16'd256;
            8'h75: w_entry = 16'd256;
            8'h76: w_entry = 16'd256;
            8'h77: w_entry = 16'd256;
            8'h78: w_entry = 16'd256;
            8'h79: w_entry = 16'd256;
            8'h7A: w_entry = 16'd256;
            8'h7B: w_entry = 16'd256;
            8'h7C: w_entry = 16'd256;
            8'h7D: w_entry = 16'd256;
            8'h7E: w_entry = 16'd256;
            8'h7F: w_entry = 16'd256;
            8'h80: w_entry = 16'd0;
            8'h81: w_entry = 16'd0;
            8'h82: w_entry = 16'd0;
            8'h83: w_entry = 16'd0;
            8'h84: w_entry = 16'd0;
            8'h85: w_entry = 16'd0;
            8'h86: w_entry = 16'd0;
            8'h87: w_entry = 16'd0;
            8'h88: w_entry = 16'd0;
            8'h89: w_entry = 16'd0;
            8'h8A: w_entry = 16'd0;
            8'h8B: w_entry = 16'd0;
            8'h8C: w_entry = 16'd0;
            8'h8D: w_entry = 16'd0;
            8'h8E: w_entry = 16'd0;
            8'h8F: w_entry = 16'd0;
            8'h90: w_entry = 16'd0;
            8'h91: w_entry = 16'd0;
            8'h92: w_entry = 16'd0;
            8'h93: w_entry = 16'd0;
            8'h94: w_entry = 16'd0;
            8'h95: w_entry = 16'd0;
            8'h96: w_entry = 16'd0;
            8'h97: w_entry = 16'd0;
            8'h98: w_entry = 16'd0;
            8'h99: w_entry = 16'd0;
            8'h9A: w_entry = 16'd0;
            8'h9B: w_entry = 16'd0;
            8'h9C: w_entry = 16'd0;
            8'h9D: w_entry = 16'd1;
            8'h9E: w_entry = 16'd1;
            8'h9F: w_entry = 16'd1;
            8'hA0: w_entry = 16'd1;
            8'hA1: w_entry = 16'd1;
            8'hA2: w_entry = 16'd1;
            8'hA3: w_entry = 16'd1;
            8'hA4: w_entry = 16'd1;
            8'hA5: w_entry = 16'd1;
            8'hA6: w_entry = 16'd1;
            8'hA7: w_entry = 16'd1;
            8'hA8: w_entry = 16'd1;
            8'hA9: w_entry = 16'd1;
            8'hAA: w_entry = 16'd1;
            8'hAB: w_entry = 16'd1;
            8'hAC: w_entry = 16'd1;
            8'hAD: w_entry = 16'd1;
            8'hAE: w_entry = 16'd2;
            8'hAF: w_entry = 16'd2;
            8'hB0: w_entry = 16'd2;
            8'hB1: w_entry = 16'd2;
            8'hB2: w_entry = 16'd2;
            8'hB3: w_entry = 16'd2;
            8'hB4: w_entry = 16'd2;
            8'hB5: w_entry = 16'd2;
            8'hB6: w_entry = 16'd2;
            8'hB7: w_entry = 16'd3;
            8'hB8: w_entry = 16'd3;
            8'hB9: w_entry = 16'd3;
            8'hBA: w_entry = 16'd3;
            8'hBB: w_entry = 16'd3;
            8'hBC: w_entry = 16'd4;
            8'hBD: w_entry = 16'd4;
            8'hBE: w_entry = 16'd4;
            8'hBF: w_entry = 16'd4;
            8'hC0: w_entry = 16'd5;
            8'hC1: w_entry = 16'd5;
            8'hC2: w_entry = 16'd5;
            8'hC3: w_entry = 16'd6;
            8'hC4: w_entry = 16'd6;
            8'hC5: w_entry = 16'd6;
            8'hC6: w_entry = 16'd7;
            8'hC7: w_entry = 16'd7;
            8'hC8: w_entry = 16'd8;
            8'hC9: w_entry = 16'd8;
            8'hCA: w_entry = 16'd8;
            8'hCB: w_entry = 16'd9;
            8'hCC: w_entry = 16'd10;
            8'hCD: w_entry = 16'd10;
            8'hCE: w_entry = 16'd11;
            8'hCF: w_entry = 16'd11;
            8'hD0: w_entry = 16'd12;
            8'hD1: w_entry = 16'd13;
            8'hD2: w_entry = 16'd14;
            8'hD3: w_entry = 16'd15;
            8'hD4: w_entry = 16'd15;
            8'hD5: w_entry = 16'd16;
            8'hD6: w_entry = 16'd17;
            8'hD7: w_entry = 16'd18;
            8'hD8: w_entry = 16'd19;
            8'hD9: w_entry = 16'd21;
            8'hDA: w_entry = 16'd22;
            8'hDB: w_entry = 16'd23;
            8'hDC: w_entry = 16'd24;
            8'hDD: w_entry = 16'd26;
            8'hDE: w_entry = 16'd27;
            8'hDF: w_entry = 16'd29;
            8'hE0: w_entry = 16'd31;
            8'hE1: w_entry = 16'd32;
            8'hE2: w_entry = 16'd34;
            8'hE3: w_entry = 16'd36;
            8'hE4: w_entry = 16'd38;
            8'hE5: w_entry = 16'd40;
            8'hE6: w_entry = 16'd42;
            8'hE7: w_entry = 16'd44;
            8'hE8: w_entry = 16'd47;
            8'hE9: w_entry = 16'd49;
            8'hEA: w_entry = 16'd52;
            8'hEB: w_entry = 16'd54;
            8'hEC: w_entry = 16'd57;
            8'hED: w_entry = 16'd60;
            8'hEE: w_entry = 16'd63;
            8'hEF: w_entry = 16'd66;
            8'hF0: w_entry = 16'd69;
            8'hF1: w_entry = 16'd72;
            8'hF2: w_entry = 16'd75;
            8'hF3: w_entry = 16'd79;
            8'hF4: w_entry = 16'd82;
            8'hF5: w_entry = 16'd86;
            8'hF6: w_entry = 16'd89;
            8'hF7: w_entry = 16'd93;
            8'hF8: w_entry = 16'd97;
            8'hF9: w_entry = 16'd100;
            8'hFA: w_entry = 16'd104;
            8'hFB: w_entry = 16'd108;
            8'hFC: w_entry = 16'd112;
            8'hFD: w_entry = 16'd116;
            8'hFE: w_entry = 16'd120;
            8'hFF: w_entry = 16'd124;
        endcase
    end

    // Reset has priority over enable. With en low the register holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= 16'h0000;
        end else if (en) begin
            r_sig <= w_entry;
        end
    end

    assign sig = r_sig;

endmodule

// File: tb/tb_lut_sigmoid.sv
module tb_lut_sigmoid;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  x;
    logic [15:0] sig;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    logic [15:0] seen [256];

    lut_sigmoid dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .x   (x),
        .sig (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Real-valued reference: round_half_up(256 / (1 + e^-v)), v = code/16
    function automatic logic [15:0] model(input logic [7:0] code);
        real v;
        real y;
        int  r;
        v = $itor($signed(code)) / 16.0;
        y = 256.0 / (1.0 + $exp(-v));
        r = int'($floor(y + 0.5));
        return 16'(r);
    endfunction

    // Drive inputs away from the active edge, then sample 1 ns after it
    task automatic cycle(input logic r, input logic e, input logic [7:0] xv);
        @(negedge clk);
        rst = r;
        en  = e;
        x   = xv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        pass_cnt  = 0;
        fail_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        en  = 1'b1;
        x   = 8'h7F;

        // Reset wins over enable
        cycle(1'b1, 1'b1, 8'h7F);
        chk("reset_edge1", sig, 16'h0000);
        cycle(1'b1, 1'b1, 8'h7F);
        chk("reset_edge2", sig, 16'h0000);
        cycle(1'b0, 1'b1, 8'h7F);
        chk("release_7F", sig, 16'h0100);
        $display("reset sequence done, sig=%h", sig);

        // Back-to-back stream around zero
        cycle(1'b0, 1'b1, 8'hFE); chk("stream_FE", sig, 16'h0078);
        cycle(1'b0, 1'b1, 8'hFF); chk("stream_FF", sig, 16'h007C);
        cycle(1'b0, 1'b1, 8'h00); chk("stream_00", sig, 16'h0080);
        cycle(1'b0, 1'b1, 8'h01); chk("stream_01", sig, 16'h0084);
        cycle(1'b0, 1'b1, 8'h02); chk("stream_02", sig, 16'h0088);

        // Extremes and landmarks
        cycle(1'b0, 1'b1, 8'h80); chk("land_80", sig, 16'h0000);
        cycle(1'b0, 1'b1, 8'hC0); chk("land_C0", sig, 16'h0005);
        cycle(1'b0, 1'b1, 8'hE0); chk("land_E0", sig, 16'h001F);
        cycle(1'b0, 1'b1, 8'h10); chk("land_10", sig, 16'h00BB);
        cycle(1'b0, 1'b1, 8'h20); chk("land_20", sig, 16'h00E1);
        cycle(1'b0, 1'b1, 8'h40); chk("land_40", sig, 16'h00FB);
        cycle(1'b0, 1'b1, 8'h7F); chk("land_7F", sig, 16'h0100);
        $display("landmarks done");

        // Hold with en low across every code
        cycle(1'b0, 1'b1, 8'h10);
        chk("hold_load", sig, 16'h00BB);
        for (int i = -128; i < 128; i++) begin
            cycle(1'b0, 1'b0, 8'(i));
            chk("hold_sweep", sig, 16'h00BB);
        end
        $display("hold sweep done");

        // Reset pulse between edges must not affect the register
        @(negedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("async_pulse_ignored", sig, 16'h00BB);

        cycle(1'b0, 1'b1, 8'h00);
        chk("reenable_00", sig, 16'h0080);

        // Exhaustive sweep in signed order against the real-valued model
        for (int i = -128; i < 128; i++) begin
            logic [7:0] c;
            c = 8'(i);
            cycle(1'b0, 1'b1, c);
            seen[c] = sig;
            chk("sweep_model", sig, model(c));
        end
        $display("exhaustive sweep done");

        // Table properties from the captured sweep
        for (int i = -127; i < 128; i++) begin
            logic [7:0] c;
            logic [7:0] p;
            c = 8'(i);
            p = 8'(i - 1);
            chk("monotonic", {15'd0, seen[c] >= seen[p]}, 16'h0001);
        end
        for (int i = 1; i < 128; i++) begin
            logic [7:0] c;
            logic [7:0] n;
            c = 8'(i);
            n = 8'(-i);
            chk("symmetry", seen[c] + seen[n], 16'h0100);
        end
        for (int i = 0; i < 256; i++) begin
            chk("upper_bits_zero", {9'd0, seen[i][15:9]}, 16'h0000);
        end
        $display("property checks done");

        // Mid-stream reset at code 0x40
        for (int i = 'h38; i < 'h48; i++) begin
            logic [7:0] c;
            c = 8'(i);
            if (c == 8'h40) begin
                cycle(1'b1, 1'b1, c);
                chk("midstream_reset", sig, 16'h0000);
            end else begin
                cycle(1'b0, 1'b1, c);
                chk("midstream_resume", sig, model(c));
            end
        end
        cycle(1'b0, 1'b1, 8'h41);
        chk("after_reset_41", sig, 16'h00FC);
        $display("mid-stream reset done");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lut_sigmoid.md
# lut_sigmoid

Lookup-table sigmoid activation for the fixed-point neural-network datapath. It takes a signed 8-bit Q4.4 pre-activation and returns σ(x) = 1/(1+e^(−x)) as an unsigned 16-bit Q8.8 value, registered on the clock. It sits after the neuron accumulate/quantise stage and feeds the next layer's multipliers. It is a 256-entry constant table with no arithmetic at run time.

## Interface

- No parameters. Widths and the table contents are fixed.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: lookup enable, sampled at the rising edge.
- `x` input 8: pre-activation, two's-complement Q4.4 (bit 7 sign, bits 6:4 integer, bits 3:0 fraction). Range −8.0 (0x80) to +7.9375 (0x7F).
- `sig` output 16: σ(x), unsigned Q8.8 (bits 15:8 integer, bits 7:0 fraction). Range 0x0000 to 0x0100.

## Operation

- Table entry for each code k (interpreted as signed Q4.4 value v = k/16):
  - entry = round_half_up(256 / (1 + e^(−v))), stored as 16 bits.
  - Entries are precomputed in double precision and hard-coded in the RTL as a full 256-way case or ROM.
- Table properties, which are mandatory and checkable:
  - Monotonic non-decreasing in signed v.
  - entry(0x00) = 0x0080.
  - For every k ≠ 0x80: entry(k) + entry(−k) = 0x0100.
  - entry(0x80) = 0x0000 and entry(0x7F) = 0x0100. The Q8.8 representation of 1.0 is permitted; no saturation to 0x00FF.
  - Bits 15:9 of every entry are 0.
- Reference entries:
  - 0x80→0x0000, 0xC0→0x0005, 0xE0→0x001F.
  - 0xFE→0x0078, 0xFF→0x007C, 0x00→0x0080, 0x01→0x0084, 0x02→0x0088.
  - 0x10→0x00BB, 0x20→0x00E1, 0x40→0x00FB, 0x7F→0x0100.
- Register update at each rising edge of `clk`, in priority order:
  - `rst`=1: `sig` ← 0x0000, regardless of `en`.
  - `rst`=0, `en`=1: `sig` ← entry(x).
  - `rst`=0, `en`=0: `sig` holds its previous value.
- `x` is don't-care when `en`=0. X/Z on `x` while `en`=1 is a bench error, not a design requirement.

## Timing

- Latency is 1 cycle: the value of `x` at edge N appears on `sig` immediately after edge N, when `en`=1 at edge N.
- Throughput is one lookup per cycle. Back-to-back `en`=1 with a changing `x` updates `sig` every cycle.
- No combinational path from `x` or `en` to `sig`. The output is driven directly by a flop.
- Reset value of `sig` is 0x0000. Reset is sampled only at the clock edge, so an asynchronous `rst` pulse between edges has no effect.
- Reset asserted during a stream of lookups: `sig` is 0x0000 after that edge. The first valid lookup follows the first edge with `rst`=0 and `en`=1.
- No handshake and no back-pressure. Downstream logic tracks validity by delaying `en` one cycle externally.

## Test plan

- Reset: hold `rst`=1 for 2 cycles with `en`=1 and `x`=0x7F -> `sig`=0x0000 after each edge. Release `rst` -> `sig`=0x0100 after the next edge.
- Directed stream with `en`=1: `x` = 0xFE, 0xFF, 0x00, 0x01 on consecutive edges -> `sig` = 0x0078, 0x007C, 0x0080, 0x0084 one cycle later each.
- Extremes and landmarks: `x` = 0x80, 0xC0, 0xE0, 0x10, 0x20, 0x40, 0x7F -> `sig` = 0x0000, 0x0005, 0x001F, 0x00BB, 0x00E1, 0x00FB, 0x0100.
- Hold: load `x`=0x10 with `en`=1 (`sig`=0x00BB). Then set `en`=0 and sweep `x` through 0x80..0x7F -> `sig` stays 0x00BB. Re-enable with `x`=0x00 -> `sig`=0x0080.
- Exhaustive sweep of all 256 codes with `en`=1, compared against a real-valued model with round-half-up -> exact match. Also check monotonicity, the symmetry sum 0x0100, and bits 15:9 = 0.
- Mid-stream reset: run the sweep and assert `rst` for 1 cycle at code 0x40 -> `sig`=0x0000 for that cycle, then correct entries resume from the next enabled edge.
